// File: rtl/fifo_write_arbiter_if.sv
// Bundle of producer handshakes and the FIFO write port shared by the
// round-robin write arbiter. master = arbiter side, slave = producers/FIFO side.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        grant;
  logic                      fifo_full;
  logic                      fifo_wr_en;
  logic [DATA_W-1:0]         fifo_data;
  logic                      busy;

  modport master (
    input  req, req_data, fifo_full,
    output req_ready, grant, fifo_wr_en, fifo_data, busy
  );

  modport slave (
    output req, req_data, fifo_full,
    input  req_ready, grant, fifo_wr_en, fifo_data, busy
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ byte producers.
// An owner keeps the port for up to MAX_BURST accepted writes, then the grant
// rotates through one dead IDLE cycle. Writes back off while the FIFO is full.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input logic                  clk,
  input logic                  rst,
  fifo_write_arbiter_if.master bus
);

  localparam int              IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0]      LP_MAX_BURST = 4'(MAX_BURST);
  localparam logic [NUM_REQ-1:0] LP_ONE    = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_last_owner;
  logic [3:0]         r_burst_cnt;
  logic               r_busy;

  logic               w_any;
  logic [IDX_W-1:0]   w_sel;
  int                 w_idx;
  logic               w_owner_req;
  logic               w_accept;
  logic               w_burst_done;
  logic [DATA_W-1:0]  w_data;

  // Round-robin search: first requester after the previous owner, wrapping.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    w_any = 1'b0;
    w_sel = '0;
    w_idx = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = (int'(r_last_owner) + k) % NUM_REQ;
      if (!w_any && bus.req[IDX_W'(w_idx)]) begin
        w_any = 1'b1;
        w_sel = IDX_W'(w_idx);
      end
    end
  end

  // Accept decode for the current owner; nothing is written during reset.
  always_comb begin
    w_owner_req  = bus.req[r_owner];
    w_accept     = (r_state == GRANT) && w_owner_req && !bus.fifo_full && !rst;
    w_burst_done = (r_burst_cnt + 4'd1) == LP_MAX_BURST;
    w_data       = (r_grant != '0) ? bus.req_data[int'(r_owner)*DATA_W +: DATA_W] : '0;
  end

  assign bus.fifo_wr_en = w_accept;
  assign bus.req_ready  = w_accept ? r_grant : '0;
  assign bus.fifo_data  = w_data;
  assign bus.grant      = r_grant;
  assign bus.busy       = r_busy;

  // Arbitration FSM: grant in IDLE, count accepted writes in GRANT, rotate on
  // burst completion or when the owner stops requesting.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // regardless of the order of statements in this block.
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_owner      <= '0;
      r_last_owner <= IDX_W'(NUM_REQ - 1);
      r_burst_cnt  <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state     <= GRANT;
            r_grant     <= LP_ONE << w_sel;
            r_owner     <= w_sel;
            r_burst_cnt <= '0;
            r_busy      <= 1'b1;
          end
        end
        GRANT: begin
          if (w_accept) begin
            r_burst_cnt <= r_burst_cnt + 4'd1;
          end
          // Owner drop or last write of the burst both release the port.
          if (!w_owner_req || (w_accept && w_burst_done)) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_busy       <= 1'b0;
            r_last_owner <= r_owner;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter (NUM_REQ=4, MAX_BURST=2, 8-deep FIFO
// model). Directed scenarios push expected writes; a negedge monitor pops and
// compares every write the DUT presents.
module tb_fifo_write_arbiter;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int MB    = 2;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [NR-1:0] grant;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) u_if ();

  fifo_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  wr_t           sb_q[$];
  logic [DW-1:0] p_q [NR][$];
  logic [DW-1:0] fifo_q[$];
  logic          force_full = 1'b0;
  bit            auto_drain = 1'b0;
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            first_wr_cyc = -1;
  int            last_wr_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_wr(input logic [NR-1:0] g, input logic [DW-1:0] d);
    wr_t e;
    e.grant = g;
    e.data  = d;
    sb_q.push_back(e);
  endtask

  // Drive producer valids/bytes and FIFO full from the bench models.
  task automatic apply();
    for (int i = 0; i < NR; i++) begin
      u_if.req[i]               = (p_q[i].size() > 0);
      u_if.req_data[i*DW +: DW] = (p_q[i].size() > 0) ? p_q[i][0] : '0;
    end
    u_if.fifo_full = force_full || (fifo_q.size() >= DEPTH);
  endtask

  // One clock: sample handshakes/writes at the edge, update models, re-drive.
  task automatic tick();
    logic [NR-1:0] hs;
    logic          wr;
    logic [DW-1:0] d;
    @(posedge clk);
    hs = u_if.req & u_if.req_ready;
    wr = u_if.fifo_wr_en;
    d  = u_if.fifo_data;
    #1;
    cyc++;
    if (auto_drain && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (wr) begin
      fifo_q.push_back(d);
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
    end
    for (int i = 0; i < NR; i++)
      if (hs[i]) void'(p_q[i].pop_front());
    apply();
    #1;
  endtask

  task automatic reset_dut();
    rst        = 1'b1;
    force_full = 1'b0;
    auto_drain = 1'b0;
    for (int i = 0; i < NR; i++) p_q[i].delete();
    fifo_q.delete();
    sb_q.delete();
    apply();
    repeat (2) tick();
    rst = 1'b0;
    #1;
  endtask

  // Monitor: every presented write must match the next expected write.
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      check("no_wr_while_full", 32'(u_if.fifo_wr_en & u_if.fifo_full), 32'd0);
      check("ready_onehot", 32'($countones(u_if.req_ready) <= 1), 32'd1);
      if (u_if.fifo_wr_en) begin
        if (sb_q.size() == 0) begin
          check("unexpected_write", 32'(u_if.fifo_data), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          check("wr_grant", 32'(u_if.grant), 32'(e.grant));
          check("wr_ready", 32'(u_if.req_ready), 32'(e.grant));
          check("wr_data", 32'(u_if.fifo_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    apply();

    // Reset state and single requester bursting across a rotation.
    reset_dut();
    check("rst_grant", 32'(u_if.grant), 32'd0);
    check("rst_busy", 32'(u_if.busy), 32'd0);
    check("rst_wr_en", 32'(u_if.fifo_wr_en), 32'd0);
    check("rst_ready", 32'(u_if.req_ready), 32'd0);
    check("rst_data", 32'(u_if.fifo_data), 32'd0);
    p_q[0].push_back(8'hAA);
    p_q[0].push_back(8'hBB);
    p_q[0].push_back(8'hCC);
    exp_wr(4'b0001, 8'hAA);
    exp_wr(4'b0001, 8'hBB);
    exp_wr(4'b0001, 8'hCC);
    apply(); #1;
    check("t1_grant_pre", 32'(u_if.grant), 32'd0);
    tick();
    check("t1_grant", 32'(u_if.grant), 32'b0001);
    tick(); tick();
    check("t1_idle_grant", 32'(u_if.grant), 32'd0);
    check("t1_idle_busy", 32'(u_if.busy), 32'd0);
    tick();
    check("t1_regrant", 32'(u_if.grant), 32'b0001);
    repeat (4) tick();
    check("t1_sb_empty", 32'(sb_q.size()), 32'd0);
    check("t1_fifo_cnt", 32'(fifo_q.size()), 32'd3);
    check("t1_rd0", 32'(fifo_q.pop_front()), 32'hAA);
    check("t1_rd1", 32'(fifo_q.pop_front()), 32'hBB);
    check("t1_rd2", 32'(fifo_q.pop_front()), 32'hCC);

    // Full contention: 2 writes per grant, one dead cycle per rotation.
    reset_dut();
    auto_drain = 1'b1;
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < 4; k++) p_q[i].push_back(8'(16*i + k));
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++)
        for (int k = 0; k < 2; k++)
          exp_wr(4'(1 << i), 8'(16*i + 2*r + k));
    first_wr_cyc = -1;
    apply(); #1;
    repeat (30) tick();
    check("t2_sb_empty", 32'(sb_q.size()), 32'd0);
    check("t2_write_span", 32'(last_wr_cyc - first_wr_cyc), 32'd22);

    // Full stall mid-burst for owner 1, then rotation to owner 2.
    reset_dut();
    p_q[1].push_back(8'h51);
    p_q[1].push_back(8'h52);
    p_q[2].push_back(8'h61);
    exp_wr(4'b0010, 8'h51);
    exp_wr(4'b0010, 8'h52);
    exp_wr(4'b0100, 8'h61);
    apply(); #1;
    tick();
    check("t3_grant", 32'(u_if.grant), 32'b0010);
    tick();
    force_full = 1'b1;
    apply(); #1;
    for (int c = 0; c < 3; c++) begin
      check("t3_stall_wr", 32'(u_if.fifo_wr_en), 32'd0);
      check("t3_stall_ready", 32'(u_if.req_ready), 32'd0);
      check("t3_stall_grant", 32'(u_if.grant), 32'b0010);
      if (c == 2) force_full = 1'b0;
      tick();
    end
    check("t3_resume_wr", 32'(u_if.fifo_wr_en), 32'd1);
    tick(); tick();
    check("t3_rotate", 32'(u_if.grant), 32'b0100);
    repeat (4) tick();
    check("t3_sb_empty", 32'(sb_q.size()), 32'd0);

    // Owner 2 drops after one write; search resumes from 3.
    reset_dut();
    p_q[2].push_back(8'h71);
    exp_wr(4'b0100, 8'h71);
    exp_wr(4'b1000, 8'h91);
    exp_wr(4'b0001, 8'h81);
    apply(); #1;
    tick();
    check("t4_grant", 32'(u_if.grant), 32'b0100);
    p_q[0].push_back(8'h81);
    p_q[3].push_back(8'h91);
    apply(); #1;
    check("t4_nonowner_grant", 32'(u_if.grant), 32'b0100);
    check("t4_nonowner_ready", 32'(u_if.req_ready), 32'b0100);
    tick();
    check("t4_drop_no_wr", 32'(u_if.fifo_wr_en), 32'd0);
    tick();
    check("t4_idle", 32'(u_if.grant), 32'd0);
    tick();
    check("t4_next_grant", 32'(u_if.grant), 32'b1000);
    repeat (8) tick();
    check("t4_sb_empty", 32'(sb_q.size()), 32'd0);

    // Reset while owner 2 is mid-burst.
    reset_dut();
    p_q[2].push_back(8'hA0);
    p_q[2].push_back(8'hA1);
    exp_wr(4'b0100, 8'hA0);
    apply(); #1;
    tick();
    check("t5_grant", 32'(u_if.grant), 32'b0100);
    tick();
    rst = 1'b1;
    #1;
    check("t5_rst_no_wr", 32'(u_if.fifo_wr_en), 32'd0);
    check("t5_rst_no_ready", 32'(u_if.req_ready), 32'd0);
    tick();
    check("t5_post_grant", 32'(u_if.grant), 32'd0);
    check("t5_post_busy", 32'(u_if.busy), 32'd0);
    check("t5_post_wr", 32'(u_if.fifo_wr_en), 32'd0);
    check("t5_post_ready", 32'(u_if.req_ready), 32'd0);
    check("t5_post_data", 32'(u_if.fifo_data), 32'd0);
    p_q[0].push_back(8'hB0);
    p_q[1].push_back(8'hB1);
    p_q[3].push_back(8'hB3);
    exp_wr(4'b0001, 8'hB0);
    exp_wr(4'b0010, 8'hB1);
    exp_wr(4'b0100, 8'hA1);
    exp_wr(4'b1000, 8'hB3);
    rst = 1'b0;
    apply(); #1;
    tick();
    check("t5_first_grant", 32'(u_if.grant), 32'b0001);
    repeat (16) tick();
    check("t5_sb_empty", 32'(sb_q.size()), 32'd0);

    // Fill the FIFO from producer 3 and hold the request against full.
    reset_dut();
    for (int k = 0; k < 12; k++) p_q[3].push_back(8'(8'hC0 + k));
    for (int k = 0; k < DEPTH; k++) exp_wr(4'b1000, 8'(8'hC0 + k));
    apply(); #1;
    repeat (40) tick();
    check("t6_fifo_cnt", 32'(fifo_q.size()), 32'(DEPTH));
    check("t6_full_wr", 32'(u_if.fifo_wr_en), 32'd0);
    check("t6_full_grant", 32'(u_if.grant), 32'b1000);
    check("t6_full_busy", 32'(u_if.busy), 32'd1);
    check("t6_sb_empty", 32'(sb_q.size()), 32'd0);
    p_q[3].delete();
    apply(); #1;
    for (int k = 0; k < DEPTH; k++) begin
      if (fifo_q.size() > 0) check("t6_rd", 32'(fifo_q.pop_front()), 32'(8'hC0 + k));
      else check("t6_rd_missing", 32'd0, 32'(8'hC0 + k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
